// File: rtl/alu_seq_pkg.sv
// Shared constants, FSM encodings, ALU opcodes and command payload for the ALU command sequencer.
package alu_seq_pkg;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned NREGS = 4;
  localparam int unsigned RAW   = 2;
  localparam int unsigned OPW   = 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EXEC = 1'b1;

  localparam logic [OPW-1:0] ADD  = 4'b1000;
  localparam logic [OPW-1:0] ADDC = 4'b1001;
  localparam logic [OPW-1:0] AND  = 4'b0000;
  localparam logic [OPW-1:0] XOR  = 4'b0010;

  typedef struct packed {
    logic             ld;
    logic [OPW-1:0]   op;
    logic             cin;
    logic             cin_sel;
    logic [RAW-1:0]   src_a;
    logic [RAW-1:0]   src_b;
    logic             imm_sel;
    logic [WIDTH-1:0] imm;
    logic [RAW-1:0]   dst;
    logic             wen;
  } cmd_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// Operand register file: one synchronous write port, three combinational read ports.
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [RAW-1:0]   waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [RAW-1:0]   ra_addr,
  output logic [WIDTH-1:0] ra_data,
  input  logic [RAW-1:0]   rb_addr,
  output logic [WIDTH-1:0] rb_data,
  input  logic [RAW-1:0]   rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/alu_seq.sv
// ALU command sequencer: latches operands into the ALU, captures its result one cycle later,
// writes it back and keeps sticky carry/overflow for carry chaining.
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_ld,
  input  logic [OPW-1:0]   cmd_op,
  input  logic             cmd_cin,
  input  logic             cmd_cin_sel,
  input  logic [RAW-1:0]   cmd_src_a,
  input  logic [RAW-1:0]   cmd_src_b,
  input  logic             cmd_imm_sel,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic [RAW-1:0]   cmd_dst,
  input  logic             cmd_wen,
  output logic [WIDTH-1:0] aluin_a,
  output logic [WIDTH-1:0] aluin_b,
  output logic [OPW-1:0]   OPCODE,
  output logic             Cin,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             Cout,
  input  logic             OF,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cout,
  output logic             rsp_of,
  output logic             carry_flag,
  output logic             ovf_flag,
  input  logic [RAW-1:0]   dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  cmd_t             cmd;
  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic             accept;
  logic [RAW-1:0]   dst_q;
  logic             wen_q;
  logic [WIDTH-1:0] rf_a;
  logic [WIDTH-1:0] rf_b;
  logic             rf_we;
  logic [RAW-1:0]   rf_waddr;
  logic [WIDTH-1:0] rf_wdata;

  always_comb begin
    cmd = '{ld: cmd_ld, op: cmd_op, cin: cmd_cin, cin_sel: cmd_cin_sel,
            src_a: cmd_src_a, src_b: cmd_src_b, imm_sel: cmd_imm_sel,
            imm: cmd_imm, dst: cmd_dst, wen: cmd_wen};
  end

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid & cmd_ready;

  alu_seq_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .ra_addr (cmd.src_a),
    .ra_data (rf_a),
    .rb_addr (cmd.src_b),
    .rb_data (rf_b),
    .rd_addr (dbg_addr),
    .rd_data (dbg_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Loads write at accept; ALU ops write back at the EXEC edge, so the port is never contended.
  always_comb begin
    state_nxt = state;
    rf_we     = 1'b0;
    rf_waddr  = cmd.dst;
    rf_wdata  = cmd.imm;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd.ld) rf_we     = 1'b1;
          else        state_nxt = EXEC;
        end
      end
      EXEC: begin
        rf_we     = wen_q;
        rf_waddr  = dst_q;
        rf_wdata  = alu_out;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluin_a    <= '0;
      aluin_b    <= '0;
      OPCODE     <= '0;
      Cin        <= 1'b0;
      dst_q      <= '0;
      wen_q      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_cout   <= 1'b0;
      rsp_of     <= 1'b0;
      carry_flag <= 1'b0;
      ovf_flag   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == IDLE && accept) begin
        if (cmd.ld) begin
          rsp_valid <= 1'b1;
          rsp_data  <= cmd.imm;
          rsp_cout  <= 1'b0;
          rsp_of    <= 1'b0;
        end else begin
          aluin_a <= rf_a;
          aluin_b <= cmd.imm_sel ? cmd.imm : rf_b;
          OPCODE  <= cmd.op;
          Cin     <= cmd.cin_sel ? carry_flag : cmd.cin;
          dst_q   <= cmd.dst;
          wen_q   <= cmd.wen;
        end
      end else if (state == EXEC) begin
        rsp_valid  <= 1'b1;
        rsp_data   <= alu_out;
        rsp_cout   <= Cout;
        rsp_of     <= OF;
        carry_flag <= Cout;
        ovf_flag   <= OF;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural 4-bit ALU closing the loop.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_ld, cmd_cin, cmd_cin_sel, cmd_imm_sel, cmd_wen;
  logic [OPW-1:0]   cmd_op;
  logic [RAW-1:0]   cmd_src_a, cmd_src_b, cmd_dst, dbg_addr;
  logic [WIDTH-1:0] cmd_imm, aluin_a, aluin_b, alu_out, rsp_data, dbg_data;
  logic [OPW-1:0]   OPCODE;
  logic             Cin, Cout, OF, rsp_valid, rsp_cout, rsp_of, carry_flag, ovf_flag;
  logic [WIDTH:0]   sum;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ld(cmd_ld),
    .cmd_op(cmd_op), .cmd_cin(cmd_cin), .cmd_cin_sel(cmd_cin_sel), .cmd_src_a(cmd_src_a),
    .cmd_src_b(cmd_src_b), .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm), .cmd_dst(cmd_dst),
    .cmd_wen(cmd_wen), .aluin_a(aluin_a), .aluin_b(aluin_b), .OPCODE(OPCODE), .Cin(Cin),
    .alu_out(alu_out), .Cout(Cout), .OF(OF), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_cout(rsp_cout), .rsp_of(rsp_of), .carry_flag(carry_flag), .ovf_flag(ovf_flag),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Reference ALU: ADD ignores Cin, ADDC adds it; logic ops clear carry/overflow.
  always_comb begin
    sum     = '0;
    alu_out = '0;
    Cout    = 1'b0;
    OF      = 1'b0;
    case (OPCODE)
      ADD, ADDC: begin
        sum     = {1'b0, aluin_a} + {1'b0, aluin_b} + ((OPCODE == ADDC) ? 5'(Cin) : 5'd0);
        alu_out = sum[WIDTH-1:0];
        Cout    = sum[WIDTH];
        OF      = (aluin_a[WIDTH-1] == aluin_b[WIDTH-1]) && (sum[WIDTH-1] != aluin_a[WIDTH-1]);
      end
      AND:     alu_out = aluin_a & aluin_b;
      XOR:     alu_out = aluin_a ^ aluin_b;
      default: alu_out = '0;
    endcase
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input string tag, input logic [RAW-1:0] a, input logic [WIDTH-1:0] exp);
    dbg_addr = a;
    #1;
    check(tag, 8'(dbg_data), 8'(exp));
  endtask

  task automatic send_ld(input logic [RAW-1:0] dst, input logic [WIDTH-1:0] imm);
    cmd_valid = 1'b1; cmd_ld = 1'b1; cmd_dst = dst; cmd_imm = imm; cmd_imm_sel = 1'b0;
    step();
    cmd_valid = 1'b0; cmd_ld = 1'b0;
  endtask

  task automatic send_alu(input logic [OPW-1:0] op, input logic cin, input logic cin_sel,
                          input logic [RAW-1:0] sa, input logic [RAW-1:0] sb,
                          input logic imm_sel, input logic [WIDTH-1:0] imm,
                          input logic [RAW-1:0] dst, input logic wen);
    cmd_valid = 1'b1; cmd_ld = 1'b0; cmd_op = op; cmd_cin = cin; cmd_cin_sel = cin_sel;
    cmd_src_a = sa; cmd_src_b = sb; cmd_imm_sel = imm_sel; cmd_imm = imm;
    cmd_dst = dst; cmd_wen = wen;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_ld = 1'b0; cmd_op = '0; cmd_cin = 1'b0;
    cmd_cin_sel = 1'b0; cmd_src_a = '0; cmd_src_b = '0; cmd_imm_sel = 1'b0;
    cmd_imm = '0; cmd_dst = '0; cmd_wen = 1'b0; dbg_addr = '0;
    step();
    check("rst_ready", 8'(cmd_ready), 8'd1);
    check("rst_rsp_valid", 8'(rsp_valid), 8'd0);
    rst = 1'b0;
    step();

    // Reset while an ADD is in EXEC drops it
    send_ld(2'd0, 4'b0101);
    check("pre_ld_rsp", 8'(rsp_data), 8'h5);
    send_alu(ADD, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 4'd0, 2'd1, 1'b1);
    check("pre_exec_ready", 8'(cmd_ready), 8'd0);
    check("pre_exec_a", 8'(aluin_a), 8'h5);
    rst = 1'b1;
    #1;
    check("midrst_ready", 8'(cmd_ready), 8'd1);
    check("midrst_rsp_valid", 8'(rsp_valid), 8'd0);
    check("midrst_alu_in", {aluin_a, aluin_b}, 8'h00);
    check("midrst_op_cin", {3'b0, Cin, OPCODE}, 8'h00);
    check("midrst_flags", {6'b0, carry_flag, ovf_flag}, 8'h00);
    check_reg("midrst_r0", 2'd0, 4'b0000);
    check_reg("midrst_r1", 2'd1, 4'b0000);
    step();
    rst = 1'b0;
    step();
    check("midrst_no_rsp", 8'(rsp_valid), 8'd0);

    // Back-to-back loads
    cmd_valid = 1'b1; cmd_ld = 1'b1; cmd_dst = 2'd0; cmd_imm = 4'b0110;
    step();
    check("ld0_valid", 8'(rsp_valid), 8'd1);
    check("ld0_data", {3'b0, rsp_cout, rsp_data}, 8'h06);
    cmd_dst = 2'd1; cmd_imm = 4'b0011;
    step();
    cmd_valid = 1'b0; cmd_ld = 1'b0;
    check("ld1_valid", 8'(rsp_valid), 8'd1);
    check("ld1_data", {3'b0, rsp_of, rsp_data}, 8'h03);
    check_reg("ld_r0", 2'd0, 4'b0110);
    check_reg("ld_r1", 2'd1, 4'b0011);

    // ADD R2 = R0 + R1 -> 1001 with signed overflow
    send_alu(ADD, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 4'd0, 2'd2, 1'b1);
    check("add_ready_low", 8'(cmd_ready), 8'd0);
    check("add_no_rsp_yet", 8'(rsp_valid), 8'd0);
    step();
    check("add_valid", 8'(rsp_valid), 8'd1);
    check("add_rsp", {2'b0, rsp_cout, rsp_of, rsp_data}, 8'h19);
    check("add_ovf_flag", 8'(ovf_flag), 8'd1);
    check("add_ready_back", 8'(cmd_ready), 8'd1);
    check_reg("add_r2", 2'd2, 4'b1001);
    step();
    check("add_pulse_once", 8'(rsp_valid), 8'd0);
    check("add_inputs_hold", {aluin_a, aluin_b}, 8'h63);

    // XOR then AND-immediate with dst == src
    send_alu(XOR, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 4'd0, 2'd3, 1'b1);
    step();
    check("xor_rsp", {3'b0, rsp_valid, rsp_data}, 8'h15);
    check_reg("xor_r3", 2'd3, 4'b0101);
    send_alu(AND, 1'b0, 1'b0, 2'd3, 2'd0, 1'b1, 4'b0011, 2'd3, 1'b1);
    check("and_imm_b", 8'(aluin_b), 8'h3);
    step();
    check("and_rsp", {3'b0, rsp_valid, rsp_data}, 8'h11);
    check_reg("and_r3", 2'd3, 4'b0001);

    // Carry chain: 1111 + 1 then ADDC 0 + 0 using the stored carry
    send_ld(2'd1, 4'b1111);
    send_alu(ADD, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 4'b0001, 2'd1, 1'b1);
    step();
    check("inc_rsp", {2'b0, rsp_cout, rsp_of, rsp_data}, 8'h20);
    check("inc_carry_flag", 8'(carry_flag), 8'd1);
    check_reg("inc_r1", 2'd1, 4'b0000);
    send_alu(ADDC, 1'b0, 1'b1, 2'd1, 2'd1, 1'b0, 4'd0, 2'd2, 1'b1);
    check("addc_cin", 8'(Cin), 8'd1);
    step();
    check("addc_rsp", {3'b0, rsp_valid, rsp_data}, 8'h11);
    check("addc_carry_clr", 8'(carry_flag), 8'd0);
    check_reg("addc_r2", 2'd2, 4'b0001);

    // Discarded result still updates flags
    send_ld(2'd0, 4'b0111);
    send_ld(2'd1, 4'b0101);
    send_alu(ADD, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0, 4'd0, 2'd2, 1'b0);
    step();
    check("nowen_rsp", {2'b0, rsp_cout, rsp_of, rsp_data}, 8'h1C);
    check("nowen_ovf_flag", 8'(ovf_flag), 8'd1);
    check_reg("nowen_r2_kept", 2'd2, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
